// File: rtl/lutram_2r1w_clr.sv
// lutram_2r1w_clr
//   LUT RAM with one synchronous write port and two asynchronous read ports.
//   The array has no reset of its own. A clear sequencer zeroes every entry
//   after reset or when clr is requested, walking the array one entry per clock.
//
// Ports
//   clk      rising-edge clock for writes and all state
//   rst      asynchronous active-high reset; starts a clear sweep
//   clr      request a full clear sweep (sampled on clk)
//   we       write enable
//   wa, d    write address and data
//   ra, rb   read addresses for ports A and B
//   oa, ob   combinational read data (0 while busy or when address >= DEPTH)
//   busy     a clear sweep is in progress
//   we_drop  one-cycle pulse after a write request was discarded
module lutram_2r1w_clr #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  output logic [WIDTH-1:0] oa,
  output logic [WIDTH-1:0] ob,
  output logic             busy,
  output logic             we_drop
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  // One bit wider than the address so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_next;
  logic             drop_next;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             wa_ok;
  logic             ra_ok;
  logic             rb_ok;

  logic [WIDTH-1:0] mem [DEPTH];

  assign wa_ok = {1'b0, wa} < DEPTH_X;
  assign ra_ok = {1'b0, ra} < DEPTH_X;
  assign rb_ok = {1'b0, rb} < DEPTH_X;
  assign busy  = (state == CLEAR);

  // Next-state logic and the single array write port. The sweep and user
  // writes share the port; user writes are only honoured in IDLE with no clr.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_addr   = wa;
    mem_data   = d;
    drop_next  = we && ((state == CLEAR) || clr || !wa_ok);
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = ptr;
        mem_data = '0;
        if (clr) begin
          ptr_next = '0;
        end else if (ptr == LAST_PTR) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end else if (we && wa_ok) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Control state; reset forces a fresh sweep from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= '0;
      we_drop <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      we_drop <= drop_next;
    end
  end

  // Storage array, deliberately without reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  // Zero-latency reads, masked during a sweep and for out-of-range addresses.
  assign oa = (busy || !ra_ok) ? '0 : mem[ra];
  assign ob = (busy || !rb_ok) ? '0 : mem[rb];

endmodule

// File: tb/tb_lutram_2r1w_clr.sv
// tb_lutram_2r1w_clr
//   Drives two instances (DEPTH=16 and DEPTH=12) with shared inputs and compares
//   both against a behavioural model: a remaining-sweep-cycles counter per
//   instance and a plain array of entry values.
module tb_lutram_2r1w_clr;

  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [WIDTH-1:0] oa_a, ob_a, oa_b, ob_b;
  logic             busy_a, busy_b, drop_a, drop_b;

  int checks   = 0;
  int failures = 0;

  int               depth_of [2] = '{16, 12};
  logic [WIDTH-1:0] ref_mem [2][16];
  int               clear_left [2];
  logic             ref_drop [2];

  lutram_2r1w_clr #(.WIDTH(WIDTH), .DEPTH(16), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .d(d), .ra(ra), .rb(rb),
    .oa(oa_a), .ob(ob_a), .busy(busy_a), .we_drop(drop_a)
  );

  lutram_2r1w_clr #(.WIDTH(WIDTH), .DEPTH(12), .AW(AW)) dut12 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .d(d), .ra(ra), .rb(rb),
    .oa(oa_b), .ob(ob_b), .busy(busy_b), .we_drop(drop_b)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] refRead(input int k, input logic [AW-1:0] a);
    if (clear_left[k] > 0 || int'(a) >= depth_of[k]) return '0;
    return ref_mem[k][a];
  endfunction

  // During a sweep reads are masked, so zeroing the model at sweep start is
  // observationally identical to zeroing one entry per cycle.
  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      clear_left[k] = depth_of[k];
      ref_drop[k]   = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = '0;
    end
  endtask

  task automatic modelClock();
    if (rst) begin
      modelReset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        ref_drop[k] = we && (clear_left[k] > 0 || clr || int'(wa) >= depth_of[k]);
        if (clr) begin
          clear_left[k] = depth_of[k];
          for (int i = 0; i < 16; i++) ref_mem[k][i] = '0;
        end else if (clear_left[k] > 0) begin
          clear_left[k]--;
        end else if (we && int'(wa) < depth_of[k]) begin
          ref_mem[k][wa] = d;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/oa16"},   32'(oa_a),   32'(refRead(0, ra)));
    checkOutput({tag, "/ob16"},   32'(ob_a),   32'(refRead(0, rb)));
    checkOutput({tag, "/busy16"}, 32'(busy_a), 32'(clear_left[0] > 0));
    checkOutput({tag, "/drop16"}, 32'(drop_a), 32'(ref_drop[0]));
    checkOutput({tag, "/oa12"},   32'(oa_b),   32'(refRead(1, ra)));
    checkOutput({tag, "/ob12"},   32'(ob_b),   32'(refRead(1, rb)));
    checkOutput({tag, "/busy12"}, 32'(busy_b), 32'(clear_left[1] > 0));
    checkOutput({tag, "/drop12"}, 32'(drop_b), 32'(ref_drop[1]));
  endtask

  // Inputs change just after the falling edge; outputs are checked before the
  // rising edge, so a read of wa in the write cycle must still show old data.
  task automatic applyStimulus(input logic c, input logic w, input logic [AW-1:0] a,
                               input logic [WIDTH-1:0] dat, input logic [AW-1:0] r_a,
                               input logic [AW-1:0] r_b, input string tag);
    clr = c;
    we  = w;
    wa  = a;
    d   = dat;
    ra  = r_a;
    rb  = r_b;
    #1;
    checkAll(tag);
    @(posedge clk);
    modelClock();
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, AW'($urandom), WIDTH'($urandom),
                    AW'($urandom), AW'($urandom), tag);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    we  = 1'b0;
    wa  = '0;
    d   = '0;
    ra  = '0;
    rb  = '0;
    modelReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'd1, 16'h1111, 4'd1, 4'd2, "in_reset");
    rst = 1'b0;

    // Reset sweep, then every address reads zero on both ports.
    for (int i = 0; i < 18; i++)
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, AW'(i), AW'(15 - i), "sweep");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, AW'(i), AW'(15 - i), "zero");

    // Write then read back, including same-cycle read of the write address.
    applyStimulus(1'b0, 1'b1, 4'd3,  16'hA5A5, 4'd3, 4'd15, "wr3");
    applyStimulus(1'b0, 1'b1, 4'd15, 16'h1234, 4'd3, 4'd15, "wr15");
    applyStimulus(1'b0, 1'b1, 4'd2,  16'h5555, 4'd3, 4'd15, "wr2");
    applyStimulus(1'b0, 1'b0, 4'd0,  16'h0,    4'd2, 4'd3,  "rdback");

    // Write attempted during a sweep is dropped and entry 2 ends up cleared.
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0, 4'd2, 4'd3, "clr1");
    idleCycles(4, "sw_pre");
    applyStimulus(1'b0, 1'b1, 4'd2, 16'hFFFF, 4'd2, 4'd2, "sw_wr");
    idleCycles(14, "sw_post");
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd2, 4'd3, "sw_rd");

    // clr/we collision in IDLE, then a restart mid-sweep.
    applyStimulus(1'b0, 1'b1, 4'd4, 16'h7777, 4'd4, 4'd4, "wr4");
    applyStimulus(1'b1, 1'b1, 4'd4, 16'hBEEF, 4'd4, 4'd4, "clr_we");
    idleCycles(9, "coll");
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0, 4'd4, 4'd5, "clr2");
    idleCycles(18, "coll_post");

    // Out-of-range write/read for the 12-entry instance.
    applyStimulus(1'b0, 1'b1, 4'd13, 16'h4242, 4'd13, 4'd12, "wr13");
    applyStimulus(1'b0, 1'b0, 4'd0,  16'h0,    4'd13, 4'd11, "rd13");

    // Asynchronous reset mid-sweep, asserted between edges.
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd1, "clr3");
    idleCycles(6, "pre_rst");
    rst = 1'b1;
    modelReset();
    applyStimulus(1'b0, 1'b1, 4'd5, 16'h9999, 4'd5, 4'd6, "mid_rst");
    rst = 1'b0;
    idleCycles(18, "post_rst");

    // Randomised traffic with occasional clr and reset.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b0, 1'($urandom), AW'($urandom), WIDTH'($urandom),
                      AW'($urandom), AW'($urandom), "rnd_rst");
        rst = 1'b0;
      end else begin
        applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom),
                      AW'($urandom), WIDTH'($urandom),
                      AW'($urandom), AW'($urandom), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
